hog_block_assembler: RTL
========================

HOG_BLOCK_ASSEMBLER -- requirements
Module: hog_block_assembler

Interface
REQ-001 Parameter NBIN, default 9: orientation bins per cell histogram.
REQ-002 Parameter BIN_W, default 32: width of one bin word (integer plus fraction bits).
REQ-003 Parameter CELLS_X, default 40: cells per image row, which is the line-buffer depth; minimum 2.
REQ-004 Parameter CELLS_Y, default 30: cell rows per frame; minimum 2.
REQ-005 Parameter BID_W, default 13: block id width; SHALL be >= clog2((CELLS_X-1)*(CELLS_Y-1)).
REQ-006 clk  in  1  sole clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 i_bin  in  NBIN*BIN_W  cell histogram, bin 0 in the LSBs.
REQ-009 i_valid  in  1  i_bin is valid this cycle.
REQ-010 i_sof  in  1  qualified by i_valid; marks the cell at column 0, row 0 of a new frame.
REQ-011 i_ready  out  1  block can accept a cell this cycle.
REQ-012 cell_a, cell_b, cell_c, cell_d  out  NBIN*BIN_W each  2x2 block: a = previous row, column-1; b = previous row, column; c = current row, column-1; d = current row, column.
REQ-013 bid  out  BID_W  raster index of the block within the frame.
REQ-014 o_eof  out  1  qualified by o_valid; marks the last block of the frame.
REQ-015 o_valid  out  1  outputs hold a block.
REQ-016 o_ready  in  1  downstream accepts the block.

Function
REQ-017 A cell SHALL be accepted when i_valid && i_ready.
REQ-018 i_ready SHALL equal !o_valid || o_ready, so the output stage is a single register with pass-through backpressure.
REQ-019 Column counter col (0..CELLS_X-1) and row counter row (0..CELLS_Y-1) SHALL advance on each accepted cell.
REQ-020 On an accepted cell with col == CELLS_X-1, col SHALL become 0 and row SHALL increment; on the last cell of the frame, both SHALL wrap to 0.
REQ-021 An accepted cell with i_sof=1 SHALL be treated as col=0, row=0 regardless of counter state, and SHALL reset the block id counter to 0.
REQ-022 A mid-frame i_sof SHALL abort the current frame; a block already in the output register SHALL still be delivered.
REQ-023 The line memory (CELLS_X entries x NBIN*BIN_W) SHALL be read at index col and then written with the accepted cell at col in the same cycle (read-before-write).
REQ-024 Register top_prev SHALL capture the line-memory read value of each accepted cell.
REQ-025 Register cur_prev SHALL capture each accepted cell.
REQ-026 An accepted cell with col >= 1 and row >= 1 SHALL load the output register with a = top_prev, b = memory read value, c = cur_prev, d = i_bin.
REQ-027 Loading the output register SHALL also set bid to the block id counter and o_valid to 1; the counter SHALL then increment.
REQ-028 Cells in row 0 or column 0 SHALL be accepted and stored but SHALL emit no block.
REQ-029 Latency SHALL be 1 cycle from acceptance of the cell to o_valid.
REQ-030 o_eof SHALL be 1 for the block emitted at col = CELLS_X-1, row = CELLS_Y-1.
REQ-031 o_valid SHALL clear when o_valid && o_ready and no new block loads in that cycle.
REQ-032 A simultaneous downstream accept and new load SHALL replace the register contents with no bubble.
REQ-033 While o_valid && !o_ready, all outputs SHALL hold stable and no cell SHALL be accepted.

Reset
REQ-034 While rst=0 at a clock edge: o_valid, o_eof, bid, cell_a..d, col, row, the block id counter, top_prev and cur_prev SHALL be cleared to 0.
REQ-035 While rst=0, i_ready SHALL be 0.
REQ-036 Line-memory contents SHALL not be reset; the row-0 emission rule (REQ-028) makes them don't-care.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame; the next frame starts at i_sof, or at col=0, row=0 if i_sof is absent.

Structure
REQ-038 The shared HOG package SHALL hold a cell-width function (NBIN*BIN_W) and a bid-width check function.
REQ-039 The line memory SHALL be the sub-module hog_line_mem (parameters DEPTH, DATA_W; asynchronous read, synchronous write, no reset).
REQ-040 Counters, the block-emit decision and the output register SHALL reside in hog_block_assembler.

Verification (CELLS_X=4, CELLS_Y=3, NBIN=1, BIN_W=8 unless stated)
REQ-041 Frame test: feed cells 1..12 with i_sof on cell 1 and o_ready=1 -> exactly 6 blocks with bid 0..5; the first block is a=1, b=2, c=5, d=6; the last block is a=7, b=8, c=11, d=12 with o_eof=1.
REQ-042 Backpressure test: hold o_ready=0 for 5 cycles after the first block -> i_ready=0 and outputs frozen; on release, the block sequence is identical to REQ-041.
REQ-043 Back-to-back frames: two frames streamed without gaps, the second starting with i_sof -> second frame bid restarts at 0 and its first block is built only from second-frame cells.
REQ-044 Mid-frame restart: i_sof on cell 7 -> the pending block is delivered, then the next block appears only after the new row 1, column 1 cell, with bid=0.
REQ-045 Reset test: assert rst=0 for 1 cycle after cell 6 -> all outputs read 0 and i_ready=0 during reset; a fresh frame then matches REQ-041.
REQ-046 Default-parameter test: default parameters, one full frame -> exactly 39*29=1131 blocks, the final block with bid=1130 and o_eof=1.

Source files
------------

// File: rtl/hog_block_assembler_pkg.sv
// Shared HOG definitions: the cell word width and the block-id width check used
// by the block assembler.
package hog_block_assembler_pkg;

    localparam int MIN_CELLS = 2;

    function automatic int cell_w(input int nbin, input int bin_w);
        return nbin * bin_w;
    endfunction

    // True when bid_w can number every 2x2 block of a cx-by-cy cell frame.
    function automatic bit bid_w_ok(input int bid_w, input int cx, input int cy);
        return bid_w >= $clog2((cx - 1) * (cy - 1));
    endfunction

endpackage

// File: rtl/hog_block_assembler_line_mem.sv
// One-row line buffer of cell histograms: asynchronous read, synchronous write,
// no reset (contents before the first row are never used).
module hog_line_mem #(
    parameter int DEPTH  = 40,
    parameter int DATA_W = 288
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

endmodule

// File: rtl/hog_block_assembler.sv
// Streams cell histograms in raster order and emits one 2x2 block per cell
// that has a left and an upper neighbour, through a single output register.
module hog_block_assembler
    import hog_block_assembler_pkg::*;
#(
    parameter int NBIN    = 9,
    parameter int BIN_W   = 32,
    parameter int CELLS_X = 40,
    parameter int CELLS_Y = 30,
    parameter int BID_W   = 13
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [cell_w(NBIN, BIN_W)-1:0]     i_bin,
    input  logic                               i_valid,
    input  logic                               i_sof,
    output logic                               i_ready,
    output logic [cell_w(NBIN, BIN_W)-1:0]     cell_a,
    output logic [cell_w(NBIN, BIN_W)-1:0]     cell_b,
    output logic [cell_w(NBIN, BIN_W)-1:0]     cell_c,
    output logic [cell_w(NBIN, BIN_W)-1:0]     cell_d,
    output logic [BID_W-1:0]                   bid,
    output logic                               o_eof,
    output logic                               o_valid,
    input  logic                               o_ready
);

    localparam int CW = cell_w(NBIN, BIN_W);
    localparam int XW = $clog2(CELLS_X);
    localparam int YW = $clog2(CELLS_Y);
    localparam logic [XW-1:0] COL_LAST = XW'(CELLS_X - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(CELLS_Y - 1);

    if (!bid_w_ok(BID_W, CELLS_X, CELLS_Y) || CELLS_X < MIN_CELLS || CELLS_Y < MIN_CELLS) begin : g_bad_params
        $error("hog_block_assembler: invalid CELLS_X/CELLS_Y/BID_W combination");
    end

    logic [XW-1:0]    r_col;
    logic [YW-1:0]    r_row;
    logic [BID_W-1:0] r_bid_cnt;
    logic [CW-1:0]    r_top_prev, r_cur_prev;
    logic [CW-1:0]    r_a, r_b, r_c, r_d;
    logic [BID_W-1:0] r_bid;
    logic             r_eof, r_valid;

    logic             w_ready, w_accept, w_emit, w_col_end, w_row_end;
    logic [XW-1:0]    w_col;
    logic [YW-1:0]    w_row;
    logic [CW-1:0]    w_rd;

    assign w_ready   = rst && (!r_valid || o_ready);
    assign w_accept  = i_valid && w_ready;
    // A start-of-frame cell is position (0,0) whatever the counters say.
    assign w_col     = i_sof ? '0 : r_col;
    assign w_row     = i_sof ? '0 : r_row;
    assign w_col_end = (w_col == COL_LAST);
    assign w_row_end = (w_row == ROW_LAST);
    assign w_emit    = w_accept && (w_col != '0) && (w_row != '0);

    hog_line_mem #(.DEPTH(CELLS_X), .DATA_W(CW)) u_line_mem (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_col),
        .i_wdata (i_bin),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_bid_cnt  <= '0;
            r_top_prev <= '0;
            r_cur_prev <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_bid      <= '0;
            r_eof      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_top_prev <= w_rd;
                r_cur_prev <= i_bin;
                r_col      <= w_col_end ? '0 : w_col + 1'b1;
                if (w_col_end) r_row <= w_row_end ? '0 : w_row + 1'b1;
                else           r_row <= w_row;
            end
            // The id counter also restarts after the frame's last block so an
            // unmarked following frame numbers from 0.
            if (w_accept && i_sof)  r_bid_cnt <= '0;
            else if (w_emit)        r_bid_cnt <= (w_col_end && w_row_end) ? '0 : r_bid_cnt + 1'b1;
            if (w_emit) begin
                r_a     <= r_top_prev;
                r_b     <= w_rd;
                r_c     <= r_cur_prev;
                r_d     <= i_bin;
                r_bid   <= r_bid_cnt;
                r_eof   <= w_col_end && w_row_end;
                r_valid <= 1'b1;
            end else if (o_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign i_ready = w_ready;
    assign cell_a  = r_a;
    assign cell_b  = r_b;
    assign cell_c  = r_c;
    assign cell_d  = r_d;
    assign bid     = r_bid;
    assign o_eof   = r_eof;
    assign o_valid = r_valid;

endmodule
